multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter HALT_OPCODE, default 4'b1111, opcode that stops the sequencer.
REQ-002 SHALL have parameter MAX_WAIT, default 8, maximum Mem_Ready wait cycles before bus error.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Opcode  input  4  instruction-register opcode.
REQ-006 SHALL have port Funct_field  input  4  R-type function code.
REQ-007 SHALL have port Zero  input  1  ALU zero flag.
REQ-008 SHALL have port Mem_Ready  input  1  shared-memory access complete.
REQ-009 SHALL have ports Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, ALU_Src, Reg_Write, Mem_to_Reg  output  1 each.
- IorD: 0 = PC address, 1 = ALU address.
REQ-010 SHALL have port PC_Src  output  2  next-PC source: 00 = PC+2, 01 = branch target, 10 = jump target.
REQ-011 SHALL have port ALU_op  output  4  ALU operation: 0000 = add, 0001 = sub, 0010 = sll, 0011 = and.
REQ-012 SHALL have ports State  output  3 (current state); Halted  output  1; Bus_Error  output  1.

Function
REQ-013 SHALL use state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- All strobes are 0, ALU_op is 0000 and PC_Src is 00 unless stated below.
REQ-014 FETCH SHALL behave as follows:
- Mem_Req=1, IorD=0.
- On a cycle with Mem_Ready=1: IR_Write=1, PC_Write=1, PC_Src=00 in that same cycle, then go to DECODE.
- Otherwise remain in FETCH.
REQ-015 DECODE SHALL last one cycle and latch Opcode and Funct_field internally.
- Latched values control every later state of the instruction.
REQ-016 DECODE transitions SHALL be:
- Opcode 0110 (JMP): PC_Write=1, PC_Src=10, go to FETCH.
- Opcode HALT_OPCODE: go to HALT.
- Opcodes 0111-1110 other than HALT_OPCODE: NOP, go to FETCH.
- Opcodes 0000-0101: go to EXEC.
REQ-017 EXEC SHALL drive the following, then go to the state shown:
- R-type (0000): ALU_op=funct, ALU_Src=0; go to WB.
- ADDI (0011): ALU_op=0000, ALU_Src=1; go to WB.
- LW (0001) / SW (0010): ALU_op=0000, ALU_Src=1; go to MEM.
REQ-018 EXEC for BEQ (0100) / BNE (0101) SHALL drive ALU_op=0001, ALU_Src=0, PC_Src=01, then go to FETCH.
- PC_Write=Zero for BEQ; PC_Write=!Zero for BNE.
REQ-019 MEM SHALL drive Mem_Req=1, IorD=1, and Mem_Write=1 for SW only; ALU_op=0000 and ALU_Src=1 are held.
- On Mem_Ready=1: SW goes to FETCH, LW goes to WB.
- Otherwise remain in MEM.
REQ-020 WB SHALL drive Reg_Write=1 with Mem_to_Reg=1 for LW and 0 otherwise, then go to FETCH.
REQ-021 A wait counter SHALL count consecutive FETCH/MEM cycles with Mem_Ready=0.
- Clears on Mem_Ready=1 and on every state change.
- When the count reaches MAX_WAIT, go to ERROR instead of waiting further.
REQ-022 HALT SHALL assert Halted=1 with all strobes 0, and remain until reset.
REQ-023 ERROR SHALL assert Bus_Error=1 with all strobes 0, and remain until reset.
REQ-024 Outputs are Moore-decoded from State, with two Mealy exceptions:
- FETCH IR_Write/PC_Write, which depend on Mem_Ready.
- Branch PC_Write, which depends on Zero.
- Mem_Ready and Zero SHALL be ignored in all other states.

Reset
REQ-025 reset=1 SHALL immediately force:
- State=FETCH, wait counter=0, Halted=0, Bus_Error=0, latched opcode/funct=0.
REQ-026 While reset=1 every strobe SHALL be 0, including Mem_Req.
- After reset releases, the first clock edge sees FETCH with Mem_Req=1.
REQ-027 Reset mid-access (FETCH or MEM) SHALL drop Mem_Req and Mem_Write in the same cycle, with no completion action.

Configuration
REQ-028 Macro CTRL_PERF_CNT_EN defined SHALL add 16-bit outputs Cycle_Count and Instr_Count, both reset to 0.
- Cycle_Count increments every cycle outside HALT/ERROR.
- Instr_Count increments on every transition into FETCH.
- Both wrap from 0xFFFF to 0x0000.
REQ-029 Macro CTRL_PERF_CNT_EN undefined SHALL omit both ports and the counter logic entirely.

Verification
REQ-030 R-type SUB (Opcode=0000, Funct_field=0001), Mem_Ready=1 -> State 0,1,2,4,0; ALU_op=0001 in EXEC; Reg_Write=1, Mem_to_Reg=0 in WB.
REQ-031 LW, Mem_Ready low 2 cycles in MEM -> MEM lasts 3 cycles with Mem_Req=1, IorD=1, Mem_Write=0; WB Mem_to_Reg=1; 7 cycles total.
REQ-032 BEQ with Zero=1 -> PC_Write=1, PC_Src=01 in EXEC; BNE with Zero=1 -> PC_Write=0.
REQ-033 JMP -> PC_Write=1, PC_Src=10 in DECODE; FETCH re-entered after 2 cycles.
REQ-034 Mem_Ready=0 in FETCH, MAX_WAIT=8 -> State=6, Bus_Error=1 after 8 wait cycles; stays until reset.
REQ-035 reset pulse in MEM of SW -> Mem_Req=0, Mem_Write=0, State=0 same cycle; with CTRL_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a Mem_Ready timeout into ERROR.
// Define CTRL_PERF_CNT_EN to add the Cycle_Count / Instr_Count performance counters.
module multicycle_ctrl #(
    parameter logic [3:0] HALT_OPCODE = 4'b1111,
    parameter int         MAX_WAIT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Opcode,
    input  logic [3:0]  Funct_field,
    input  logic        Zero,
    input  logic        Mem_Ready,
    output logic        Mem_Req,
    output logic        Mem_Write,
    output logic        IorD,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic        ALU_Src,
    output logic        Reg_Write,
    output logic        Mem_to_Reg,
    output logic [1:0]  PC_Src,
    output logic [3:0]  ALU_op,
    output logic [2:0]  State,
    output logic        Halted,
    output logic        Bus_Error
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0] Cycle_Count,
    output logic [15:0] Instr_Count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;

    localparam int             WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    state_t          r_state;
    state_t          w_next;
    logic [WCW-1:0]  r_wait_cnt;
    logic [WCW-1:0]  w_wait_inc;
    logic [3:0]      r_opcode;
    logic [3:0]      r_funct;

    assign w_wait_inc = r_wait_cnt + WCW'(1);
    assign State      = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_opcode   <= '0;
            r_funct    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= Opcode;
                r_funct  <= Funct_field;
            end
            // Counts only uninterrupted stalls; any state change or ready clears it.
            if ((r_state == S_FETCH || r_state == S_MEM) && !Mem_Ready && w_next == r_state)
                r_wait_cnt <= w_wait_inc;
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        Mem_Req    = 1'b0;
        Mem_Write  = 1'b0;
        IorD       = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        ALU_Src    = 1'b0;
        Reg_Write  = 1'b0;
        Mem_to_Reg = 1'b0;
        PC_Src     = 2'b00;
        ALU_op     = 4'b0000;
        Halted     = 1'b0;
        Bus_Error  = 1'b0;
        case (r_state)
            S_FETCH: begin
                Mem_Req = 1'b1;
                if (Mem_Ready) begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_wait_inc == WAIT_LIM) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                if (Opcode == OP_JMP) begin
                    PC_Write = 1'b1;
                    PC_Src   = 2'b10;
                    w_next   = S_FETCH;
                end else if (Opcode == HALT_OPCODE) begin
                    w_next = S_HALT;
                end else if (Opcode > OP_BNE) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_opcode)
                    OP_R: begin
                        ALU_op = r_funct;
                        w_next = S_WB;
                    end
                    OP_ADDI: begin
                        ALU_Src = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALU_Src = 1'b1;
                        w_next  = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        ALU_op   = 4'b0001;
                        PC_Src   = 2'b01;
                        PC_Write = (r_opcode == OP_BEQ) ? Zero : !Zero;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                Mem_Req   = 1'b1;
                IorD      = 1'b1;
                Mem_Write = (r_opcode == OP_SW);
                ALU_Src   = 1'b1;
                if (Mem_Ready)
                    w_next = (r_opcode == OP_SW) ? S_FETCH : S_WB;
                else if (w_wait_inc == WAIT_LIM)
                    w_next = S_ERROR;
            end
            S_WB: begin
                Reg_Write  = 1'b1;
                Mem_to_Reg = (r_opcode == OP_LW);
                w_next     = S_FETCH;
            end
            S_HALT:  Halted    = 1'b1;
            S_ERROR: Bus_Error = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // Reset must drop any in-flight memory request combinationally.
        if (reset) begin
            Mem_Req    = 1'b0;
            Mem_Write  = 1'b0;
            IorD       = 1'b0;
            IR_Write   = 1'b0;
            PC_Write   = 1'b0;
            ALU_Src    = 1'b0;
            Reg_Write  = 1'b0;
            Mem_to_Reg = 1'b0;
            PC_Src     = 2'b00;
            ALU_op     = 4'b0000;
            Halted     = 1'b0;
            Bus_Error  = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_instr_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_HALT && r_state != S_ERROR)
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_instr_cnt <= r_instr_cnt + 16'd1;
        end
    end

    assign Cycle_Count = r_cycle_cnt;
    assign Instr_Count = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl: a driver expands each instruction into
// per-cycle expected outputs and a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    localparam logic [3:0] HALT_OP = 4'b1111;
    localparam int         MAXW    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Opcode = 4'd0;
    logic [3:0] Funct_field = 4'd0;
    logic       Zero = 1'b0;
    logic       Mem_Ready = 1'b0;
    logic       Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, ALU_Src, Reg_Write, Mem_to_Reg;
    logic [1:0] PC_Src;
    logic [3:0] ALU_op;
    logic [2:0] State;
    logic       Halted, Bus_Error;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] Cycle_Count, Instr_Count;
`endif

    multicycle_ctrl #(.HALT_OPCODE(HALT_OP), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct_field(Funct_field),
        .Zero(Zero), .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
        .IorD(IorD), .IR_Write(IR_Write), .PC_Write(PC_Write), .ALU_Src(ALU_Src),
        .Reg_Write(Reg_Write), .Mem_to_Reg(Mem_to_Reg), .PC_Src(PC_Src), .ALU_op(ALU_op),
        .State(State), .Halted(Halted), .Bus_Error(Bus_Error)
`ifdef CTRL_PERF_CNT_EN
        , .Cycle_Count(Cycle_Count), .Instr_Count(Instr_Count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwr, iord, irw, pcw, asrc, regw, m2r;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
        logic       halted, berr;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic [15:0] cc;
        logic [15:0] ic;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    m_cc = 0;
    int    m_ic = 0;
    logic [2:0] m_prev = 3'd0;
    bit    stuck = 1'b0;

    function automatic outs_t base(input logic [2:0] st);
        outs_t o;
        o        = '0;
        o.st     = st;
        o.halted = (st == 3'd5);
        o.berr   = (st == 3'd6);
        return o;
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // One clock cycle: apply inputs, then queue what the outputs must be during that cycle.
    task automatic step(input bit rst, input bit rdy, input bit z, input logic [3:0] opc,
                        input logic [3:0] fn, input outs_t o, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; Mem_Ready = rdy; Zero = z; Opcode = opc; Funct_field = fn;
        if (rst) begin
            m_cc = 0; m_ic = 0; m_prev = 3'd0;
            e.cc = 16'd0; e.ic = 16'd0;
        end else begin
            if (m_prev != 3'd0 && o.st == 3'd0) m_ic = m_ic + 1;
            e.cc = 16'(m_cc);
            e.ic = 16'(m_ic);
            if (o.st != 3'd5 && o.st != 3'd6) m_cc = m_cc + 1;
            m_prev = o.st;
        end
        e.o = o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic s(input bit rdy, input bit z, input outs_t o, input string tag);
        step(1'b0, rdy, z, r4(), r4(), o, tag);
    endtask

    task automatic tail(input logic [2:0] st, input string tag);
        for (int k = 0; k < 3; k++) s(rb(), rb(), base(st), tag);
        stuck = 1'b1;
    endtask

    task automatic do_reset();
        step(1'b1, rb(), rb(), r4(), r4(), base(3'd0), "reset");
        stuck = 1'b0;
    endtask

    // Expand one instruction into its cycle-by-cycle expected behaviour.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int fwait,
                             input int mwait, input bit z, input bit abort);
        outs_t o;
        for (int i = 0; i < fwait; i++) begin
            o = base(3'd0); o.mreq = 1'b1;
            s(1'b0, rb(), o, "fetch_wait");
            if (i + 1 == MAXW) begin tail(3'd6, "bus_error"); return; end
        end
        o = base(3'd0); o.mreq = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        s(1'b1, rb(), o, "fetch_done");
        o = base(3'd1);
        if (op == 4'b0110) begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
        step(1'b0, rb(), rb(), op, fn, o, "decode");
        if (op == HALT_OP) begin tail(3'd5, "halt"); return; end
        if (op > 4'b0101) return;
        o = base(3'd2);
        case (op)
            4'd0: o.aluop = fn;
            4'd1, 4'd2, 4'd3: o.asrc = 1'b1;
            4'd4: begin o.aluop = 4'd1; o.pcsrc = 2'b01; o.pcw = z; end
            4'd5: begin o.aluop = 4'd1; o.pcsrc = 2'b01; o.pcw = !z; end
            default: ;
        endcase
        s(rb(), z, o, "exec");
        if (op == 4'd4 || op == 4'd5) return;
        if (op == 4'd1 || op == 4'd2) begin
            o = base(3'd3); o.mreq = 1'b1; o.iord = 1'b1; o.mwr = (op == 4'd2); o.asrc = 1'b1;
            for (int i = 0; i < mwait; i++) begin
                s(1'b0, rb(), o, "mem_wait");
                if (abort) begin do_reset(); return; end
                if (i + 1 == MAXW) begin tail(3'd6, "bus_error"); return; end
            end
            s(1'b1, rb(), o, "mem_done");
            if (op == 4'd2) return;
        end
        o = base(3'd4); o.regw = 1'b1; o.m2r = (op == 4'd1);
        s(rb(), rb(), o, "writeback");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            outs_t act;
            string tag;
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            act = {State, Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, ALU_Src, Reg_Write,
                   Mem_to_Reg, PC_Src, ALU_op, Halted, Bus_Error};
            vectors = vectors + 1;
            if (act !== e.o) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: outputs got %h expected %h (state got %0d expected %0d)",
                         tag, act, e.o, act.st, e.o.st);
            end
`ifdef CTRL_PERF_CNT_EN
            if (Cycle_Count !== e.cc || Instr_Count !== e.ic) begin
                miscompares = miscompares + 1;
                $display("FAIL %s counters: got cyc=%0d instr=%0d expected cyc=%0d instr=%0d",
                         tag, Cycle_Count, Instr_Count, e.cc, e.ic);
            end
`endif
        end
    end

    initial begin
        do_reset();
        run_instr(4'd0, 4'd1, 0, 0, 1'b0, 1'b0);     // R-type SUB
        run_instr(4'd1, 4'd0, 0, 2, 1'b0, 1'b0);     // LW with two MEM stalls
        run_instr(4'd4, 4'd0, 1, 0, 1'b1, 1'b0);     // BEQ taken
        run_instr(4'd5, 4'd0, 0, 0, 1'b1, 1'b0);     // BNE not taken
        run_instr(4'd6, 4'd0, 0, 0, 1'b0, 1'b0);     // JMP
        run_instr(4'd3, 4'd2, 2, 0, 1'b0, 1'b0);     // ADDI
        run_instr(4'd9, 4'd0, 0, 0, 1'b0, 1'b0);     // NOP opcode
        run_instr(4'd0, 4'd0, MAXW, 0, 1'b0, 1'b0);  // FETCH timeout
        do_reset();
        run_instr(HALT_OP, 4'd0, 0, 0, 1'b0, 1'b0);
        do_reset();
        run_instr(4'd2, 4'd0, 0, 2, 1'b0, 1'b1);     // SW interrupted by reset in MEM
        run_instr(4'd1, 4'd0, 0, MAXW, 1'b0, 1'b0);  // MEM timeout
        do_reset();
        repeat (150) begin
            logic [3:0] op;
            int         fw, mw;
            op = ($urandom_range(0, 3) == 0) ? r4() : 4'($urandom_range(0, 5));
            fw = ($urandom_range(0, 19) == 0) ? MAXW : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 19) == 0) ? MAXW : int'($urandom_range(0, 3));
            run_instr(op, r4(), fw, mw, rb(), 1'b0);
            if (stuck) do_reset();
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
